sc_mux_add_seq: RTL and testbench

Parametrised stochastic-computing scaled adder with a programmable select-sequence generator and frame control. It sums INUM unipolar bitstreams as a 1/INUM-scaled mux addition: each cycle one input bit is forwarded, chosen by a select index. The index follows a round-robin, bit-reversed (Sobol dimension-1), or LFSR-gated bit-reversed sequence. The block runs for a programmed bitstream length, counts output ones, and signals completion. It sits between the stochastic number generators and the bitstream-to-binary counters in the SC datapath.

---
 rtl/sc_mux_add_pkg.sv | 50 +++++
 rtl/sc_sel_gen.sv | 73 +++++++
 rtl/sc_mux_add_seq.sv | 118 +++++++++++
 tb/tb_sc_mux_add_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_mux_add_pkg.sv
// Shared types and helpers for the stochastic-computing mux adder:
// select-mode and FSM encodings, LFSR tap lookup and index bit reversal.
package sc_mux_add_pkg;

  // Select-sequence modes; encoding 3 is decoded as bit-reversed by the consumer.
  typedef enum logic [1:0] {
    MODE_RR     = 2'd0,
    MODE_BITREV = 2'd1,
    MODE_LFSR   = 2'd2
  } mode_e;

  // Frame control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Feedback tap mask for a maximal-length Fibonacci LFSR that shifts left and
  // inserts the XOR of the masked bits at bit 0. Bit (t-1) set means tap t.
  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] m;
    case (w)
      3:       m = 8'b0000_0110;  // x^3 + x^2 + 1
      4:       m = 8'b0000_1100;  // x^4 + x^3 + 1
      5:       m = 8'b0001_0100;  // x^5 + x^3 + 1
      6:       m = 8'b0011_0000;  // x^6 + x^5 + 1
      7:       m = 8'b0110_0000;  // x^7 + x^6 + 1
      default: m = 8'b1011_1000;  // x^8 + x^6 + x^5 + x^4 + 1
    endcase
    return m;
  endfunction

  // Reverse the low w bits of v (w <= 8). Shift-based so no bit index
  // depends on a run-time expression.
  function automatic logic [7:0] bit_reverse(input logic [7:0] v, input int w);
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      if (i < w) begin
        r = {r[6:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_sel_gen.sv
// Select-index generator: round-robin or bit-reversed index stepping under a
// hold counter, or bit-reversed stepping gated by a free-running LFSR.
module sc_sel_gen
  import sc_mux_add_pkg::*;
#(
  parameter  int INUM    = 8,
  parameter  int LFSR_W  = 3,
  parameter  int HOLD_W  = 4,
  localparam int LOGINUM = $clog2(INUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [LFSR_W-1:0]  i_seed,
  input  logic               i_run,
  input  logic [1:0]         i_mode,
  input  logic [HOLD_W-1:0]  i_hold,
  output logic [LOGINUM-1:0] o_sel
);

  localparam logic [7:0]        TAPS8 = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS  = TAPS8[LFSR_W-1:0];

  logic [LFSR_W-1:0]  r_lfsr;
  logic [LOGINUM-1:0] r_idx;
  logic [HOLD_W-1:0]  r_hcnt;

  logic               w_fb;
  logic [LFSR_W-1:0]  w_lfsr_nxt;
  logic [LFSR_W-1:0]  w_seed;
  logic               w_lfsr_gated;
  logic               w_step;
  logic               w_use_rev;
  logic [7:0]         w_rev8;

  assign w_fb         = ^(r_lfsr & TAPS);
  assign w_lfsr_nxt   = {r_lfsr[LFSR_W-2:0], w_fb};
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign w_seed       = (i_seed == '0) ? LFSR_W'(1) : i_seed;
  assign w_lfsr_gated = (i_mode == MODE_LFSR);
  // Gated mode steps whenever the LFSR passes through state 1, i.e. once per
  // LFSR period; the other modes step after cfg_hold extra cycles.
  assign w_step       = w_lfsr_gated ? (r_lfsr == LFSR_W'(1)) : (r_hcnt == i_hold);
  assign w_use_rev    = (i_mode != MODE_RR);
  assign w_rev8       = bit_reverse(8'(r_idx), LOGINUM);
  assign o_sel        = w_use_rev ? w_rev8[LOGINUM-1:0] : r_idx;

  // LFSR, hold counter and index: load at frame start, advance on RUN edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_W'(1);
      r_idx  <= '0;
      r_hcnt <= '0;
    end else if (i_load) begin
      r_lfsr <= w_seed;
      r_idx  <= '0;
      r_hcnt <= '0;
    end else if (i_run) begin
      r_lfsr <= w_lfsr_nxt;
      if (w_step) begin
        r_idx <= r_idx + LOGINUM'(1);
      end
      if (!w_lfsr_gated) begin
        if (w_step) begin
          r_hcnt <= '0;
        end else begin
          r_hcnt <= r_hcnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sc_mux_add_seq.sv
// Stochastic-computing 1/INUM scaled adder: forwards one input bitstream per
// cycle chosen by sc_sel_gen, runs for a programmed frame length, counts the
// ones emitted and pulses done when the count is final.
module sc_mux_add_seq
  import sc_mux_add_pkg::*;
#(
  parameter  int INUM    = 8,
  parameter  int LFSR_W  = 3,
  parameter  int CNT_W   = 8,
  parameter  int HOLD_W  = 4,
  localparam int LOGINUM = $clog2(INUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [INUM-1:0]   in,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W:0]    ones
);

  state_e             r_state;
  logic [1:0]         r_mode;
  logic [HOLD_W-1:0]  r_hold;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cyc;
  logic               r_out;
  logic               r_out_valid;
  logic [CNT_W:0]     r_ones;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [LOGINUM-1:0] w_sel;
  logic               w_bit;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_run    = (r_state == ST_RUN);
  // len 0 wraps to all-ones here, giving a full 2^CNT_W-bit frame.
  assign w_last   = (r_cyc == (r_len - CNT_W'(1)));
  assign w_bit    = in[w_sel];

  sc_sel_gen #(
    .INUM   (INUM),
    .LFSR_W (LFSR_W),
    .HOLD_W (HOLD_W)
  ) u_sel_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_seed (cfg_seed),
    .i_run  (w_run),
    .i_mode (r_mode),
    .i_hold (r_hold),
    .o_sel  (w_sel)
  );

  // Frame configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mode <= cfg_mode;
      r_hold <= cfg_hold;
      r_len  <= cfg_len;
    end
  end

  // Frame FSM, bit counter, output register and ones accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cyc       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_ones      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (start) begin
            r_cyc   <= '0;
            r_ones  <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_out       <= w_bit;
          r_out_valid <= 1'b1;
          r_ones      <= r_ones + (CNT_W+1)'(w_bit);
          r_cyc       <= r_cyc + CNT_W'(1);
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The last frame bit is on out during this cycle; drop valid after it.
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign ones      = r_ones;

endmodule

// File: tb/tb_sc_mux_add_seq.sv
// Bench for sc_mux_add_seq (INUM=4, LFSR_W=3, CNT_W=8): directed frames with
// hand-computed bit patterns and counts, plus a frame-level reference model
// compared against the outputs every cycle.
module tb_sc_mux_add_seq;

  localparam int INUM   = 4;
  localparam int LFSR_W = 3;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        cfg_mode;
  logic [HOLD_W-1:0] cfg_hold;
  logic [LFSR_W-1:0] cfg_seed;
  logic [CNT_W-1:0]  cfg_len;
  logic [INUM-1:0]   in_bits;
  logic              out_b;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [CNT_W:0]    ones;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sc_mux_add_seq #(
    .INUM   (INUM),
    .LFSR_W (LFSR_W),
    .CNT_W  (CNT_W),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_hold  (cfg_hold),
    .cfg_seed  (cfg_seed),
    .cfg_len   (cfg_len),
    .in        (in_bits),
    .out       (out_b),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .ones      (ones)
  );

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One step of a 3-bit maximal-length sequence (x^3 + x^2 + 1).
  function automatic int lfsr3_step(input int s);
    int fb;
    fb = ((s >> 2) ^ (s >> 1)) & 1;
    return ((s << 1) | fb) & 7;
  endfunction

  // Select index for frame bit k, from the sequence definition directly.
  function automatic int sel_at(input int k, input int mode, input int hold, input int seed);
    int idx;
    int s;
    int steps;
    if (mode == 2) begin
      s = (seed == 0) ? 1 : seed;
      steps = 0;
      for (int j = 0; j < k; j++) begin
        if (s == 1) steps++;
        s = lfsr3_step(s);
      end
      idx = steps % INUM;
    end else begin
      idx = (k / (hold + 1)) % INUM;
    end
    if (mode == 0) return idx;
    return ((idx & 1) << 1) | ((idx >> 1) & 1);
  endfunction

  int   m_phase = 0;   // 0 idle, 1 run, 2 done
  int   m_k     = 0;
  int   m_len   = 0;
  int   m_mode  = 0;
  int   m_hold  = 0;
  int   m_seed  = 0;
  logic m_out   = 1'b0;
  logic m_v     = 1'b0;
  int   m_ones  = 0;
  int   m_sel;

  always_comb m_sel = sel_at(m_k, m_mode, m_hold, m_seed);

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_out   <= 1'b0;
      m_v     <= 1'b0;
      m_ones  <= 0;
      m_k     <= 0;
    end else begin
      case (m_phase)
        0: begin
          m_v <= 1'b0;
          if (start) begin
            m_phase <= 1;
            m_k     <= 0;
            m_len   <= (cfg_len == 0) ? 256 : int'(cfg_len);
            m_mode  <= int'(cfg_mode);
            m_hold  <= int'(cfg_hold);
            m_seed  <= int'(cfg_seed);
            m_ones  <= 0;
          end
        end
        1: begin
          m_out  <= in_bits[m_sel];
          m_v    <= 1'b1;
          m_ones <= m_ones + int'(in_bits[m_sel]);
          m_k    <= m_k + 1;
          if (m_k == m_len - 1) m_phase <= 2;
        end
        default: begin
          m_v     <= 1'b0;
          m_phase <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc out_valid", out_valid, int'(m_v));
      chk("cyc busy", busy, int'(m_phase != 0));
      chk("cyc done", done, int'(m_phase == 2));
      chk("cyc ones", ones, m_ones);
      if (m_v) chk("cyc out", out_b, int'(m_out));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_frame(input int mode, input int hold, input int seed, input int len,
                           input logic [3:0] inv, input bit rnd, input int poke,
                           input logic [7:0] exp_bits, input int exp_ones, input string nm);
    int n;
    logic [7:0] got;
    n   = (len == 0) ? 256 : len;
    got = '0;
    @(negedge clk);
    cfg_mode = 2'(mode);
    cfg_hold = HOLD_W'(hold);
    cfg_seed = LFSR_W'(seed);
    cfg_len  = CNT_W'(len);
    in_bits  = inv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Disturb the configuration; the running frame must not notice.
    cfg_mode = ~cfg_mode;
    cfg_hold = cfg_hold + HOLD_W'(3);
    cfg_seed = cfg_seed + LFSR_W'(1);
    cfg_len  = CNT_W'(3);
    for (int i = 0; i < n; i++) begin
      if (rnd) in_bits = 4'($urandom);
      start = (i == poke);
      @(negedge clk);
      if (i < 8) got[i] = out_b;
    end
    start = 1'b0;
    if (exp_ones >= 0) begin
      chk({nm, " bits"}, got, int'(exp_bits));
      chk({nm, " ones"}, ones, exp_ones);
      chk({nm, " done"}, done, 1);
    end
    @(negedge clk);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle done"}, done, 0);
    chk({nm, " idle ones held"}, ones, m_ones);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cfg_mode = '0;
    cfg_hold = '0;
    cfg_seed = '0;
    cfg_len  = '0;
    in_bits  = '0;
    repeat (3) @(negedge clk);
    chk("reset out", out_b, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ones", ones, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Bit-reversed: sel 0,2,1,3,... picks stream 0 on cycles 0 and 4.
    run_frame(1, 0, 0, 8, 4'b0001, 1'b0, -1, 8'b0001_0001, 2, "bitrev");
    // Round-robin hold 1: sel 0,0,1,1,2,2,3,3.
    run_frame(0, 1, 0, 8, 4'b0010, 1'b0, -1, 8'b0000_1100, 2, "rr_hold1");
    // LFSR-gated: index steps after cycle 0 only within 8 bits.
    run_frame(2, 0, 1, 8, 4'b0100, 1'b0, -1, 8'b1111_1110, 7, "lfsr_seed1");
    run_frame(2, 0, 0, 8, 4'b0100, 1'b0, -1, 8'b1111_1110, 7, "lfsr_seed0");
    // len 0 means 256 bits.
    run_frame(1, 0, 0, 0, 4'b1111, 1'b0, -1, 8'hFF, 256, "len256");
    // start during RUN is ignored.
    run_frame(1, 0, 0, 8, 4'b0001, 1'b0, 3, 8'b0001_0001, 2, "start_in_run");
    // Mode 3 behaves as bit-reversed.
    run_frame(3, 0, 0, 8, 4'b0001, 1'b0, -1, 8'b0001_0001, 2, "mode3");

    // Reset at RUN cycle 3.
    @(negedge clk);
    cfg_mode = 2'd1; cfg_hold = '0; cfg_seed = '0; cfg_len = CNT_W'(8);
    in_bits  = 4'b0001;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset ones", ones, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out", out_b, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst ones", ones, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst done", done, 0);
    run_frame(1, 0, 0, 8, 4'b0001, 1'b0, -1, 8'b0001_0001, 2, "after_rst");

    // Model-checked frames with changing inputs.
    run_frame(0, 2, 5, 12, 4'b0000, 1'b1, -1, 8'h00, -1, "rnd_rr");
    run_frame(2, 0, 6, 20, 4'b0000, 1'b1, -1, 8'h00, -1, "rnd_lfsr");
    run_frame(1, 3, 0, 10, 4'b0000, 1'b1, 4, 8'h00, -1, "rnd_bitrev");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
